// File: rtl/wb_commit_stage.sv
// wb_commit_stage: multi-lane in-order writeback/commit stage.
// Takes a group of up to LANES instructions from the memory stage, retires them
// in order in one cycle, drives the register-file write ports, selects the oldest
// exception (lowest bit = highest priority) and raises a one-cycle flush.
// Also keeps retired-instruction and taken-exception counters.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   ms_to_ws_valid .. ms_error_va  per-lane group from the memory stage
//   break_point                 stall request (blocks commit)
//   ws_allowin                  stage can accept a new group
//   ws_valid                    registered per-lane valid
//   rf_we/rf_waddr/rf_wdata     per-lane register-file write port
//   excp_flush/ertn_flush       one-cycle flush pulses
//   excp_idx/csr_era            winning exception bit / PC of flushing lane
//   va_error/bad_va             faulting address for address exceptions
//   retire_cnt/excp_cnt         performance counters (wrap)
module wb_commit_stage #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXCP_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [LANES-1:0]            ms_to_ws_valid,
    input  logic [LANES*32-1:0]         ms_pc,
    input  logic [LANES-1:0]            ms_gr_we,
    input  logic [LANES*5-1:0]          ms_dest,
    input  logic [LANES*DATA_W-1:0]     ms_result,
    input  logic [LANES*EXCP_W-1:0]     ms_excp_num,
    input  logic [LANES-1:0]            ms_ertn,
    input  logic [LANES*32-1:0]         ms_error_va,
    input  logic                        break_point,
    output logic                        ws_allowin,
    output logic [LANES-1:0]            ws_valid,
    output logic [LANES-1:0]            rf_we,
    output logic [LANES*5-1:0]          rf_waddr,
    output logic [LANES*DATA_W-1:0]     rf_wdata,
    output logic                        excp_flush,
    output logic                        ertn_flush,
    output logic [$clog2(EXCP_W)-1:0]   excp_idx,
    output logic [31:0]                 csr_era,
    output logic                        va_error,
    output logic [31:0]                 bad_va,
    output logic [CNT_W-1:0]            retire_cnt,
    output logic [CNT_W-1:0]            excp_cnt
);

    localparam int unsigned IDX_W  = $clog2(EXCP_W);
    localparam int unsigned RCNT_W = $clog2(LANES + 1);

    // Registered group
    logic [LANES*32-1:0]     pc_q;
    logic [LANES-1:0]        gr_we_q;
    logic [LANES*5-1:0]      dest_q;
    logic [LANES*DATA_W-1:0] result_q;
    logic [LANES*EXCP_W-1:0] excp_q;
    logic [LANES-1:0]        ertn_q;
    logic [LANES*32-1:0]     eva_q;

    logic                    ready_go;
    logic [LANES-1:0]        in_valid;
    logic [LANES-1:0]        lane_excp;
    logic [LANES-1:0]        lane_kill;
    logic [LANES-1:0]        commit;
    logic [LANES-1:0]        we_raw;
    logic                    same_dest;

    logic                    flush_found;
    logic                    f_excp;
    logic                    f_ertn;
    logic                    f_commit;
    logic [31:0]             f_pc;
    logic [31:0]             f_eva;
    logic [EXCP_W-1:0]       f_vec;
    logic [IDX_W-1:0]        win_idx;
    int unsigned             win_num;
    logic [RCNT_W-1:0]       retire_num;
    logic                    flush_any;

    assign ready_go   = ~break_point;
    assign ws_allowin = ~(|ws_valid) | ready_go;
    assign rf_waddr   = dest_q;
    assign rf_wdata   = result_q;

    // Lane-1 specific logic; vanishes entirely for a single-lane build
    if (LANES > 1) begin : g_dual
        // lane 1 alone is illegal and is dropped
        assign in_valid  = {ms_to_ws_valid[1] & ms_to_ws_valid[0], ms_to_ws_valid[0]};
        // an excepting or ertn lane 0 kills its younger neighbour
        assign lane_kill = {ws_valid[0] & (lane_excp[0] | ertn_q[0]), 1'b0};
        assign same_dest = (dest_q[4:0] == dest_q[9:5]);
    end else begin : g_single
        assign in_valid  = ms_to_ws_valid;
        assign lane_kill = 1'b0;
        assign same_dest = 1'b0;
    end

    // Per-lane exception presence and commit qualification
    always_comb begin
        lane_excp = '0;
        commit    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_excp[i] = |excp_q[i*EXCP_W +: EXCP_W];
            commit[i]    = ready_go & ws_valid[i];
        end
    end

    // Flush lane: lowest valid lane carrying an exception or ertn
    always_comb begin
        flush_found = 1'b0;
        f_excp      = 1'b0;
        f_ertn      = 1'b0;
        f_commit    = 1'b0;
        f_pc        = '0;
        f_eva       = '0;
        f_vec       = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (ws_valid[i] && !lane_kill[i] && (lane_excp[i] || ertn_q[i])) begin
                flush_found = 1'b1;
                f_excp      = lane_excp[i];
                f_ertn      = ertn_q[i];
                f_commit    = commit[i];
                f_pc        = pc_q[i*32 +: 32];
                f_eva       = eva_q[i*32 +: 32];
                f_vec       = excp_q[i*EXCP_W +: EXCP_W];
            end
        end
    end

    // Priority encoder: lowest set bit wins
    always_comb begin
        win_idx = '0;
        for (int j = EXCP_W - 1; j >= 0; j--) begin
            if (f_vec[j]) begin
                win_idx = IDX_W'(j);
            end
        end
        win_num = 32'(win_idx);
    end

    // Flush pulses and exception detail
    always_comb begin
        excp_flush = flush_found & f_commit & f_excp;
        ertn_flush = flush_found & f_commit & f_ertn & ~f_excp;
        excp_idx   = win_idx;
        csr_era    = f_pc;
        va_error   = 1'b0;
        bad_va     = '0;
        if (excp_flush) begin
            if (win_num >= 1 && win_num <= 4) begin
                // fetch-side address faults report the PC
                va_error = 1'b1;
                bad_va   = f_pc;
            end else if (win_num == 9 || (win_num >= 11 && win_num <= 15)) begin
                // data-side address faults report the access VA
                va_error = 1'b1;
                bad_va   = f_eva;
            end
        end
    end

    assign flush_any = excp_flush | ertn_flush;

    // Register-file writes and retire count
    always_comb begin
        we_raw     = '0;
        retire_num = '0;
        for (int i = 0; i < LANES; i++) begin
            we_raw[i] = commit[i] & gr_we_q[i] & (dest_q[i*5 +: 5] != 5'd0)
                      & ~lane_excp[i] & ~lane_kill[i];
            if (commit[i] && !lane_excp[i] && !lane_kill[i]) begin
                retire_num = retire_num + RCNT_W'(1);
            end
        end
        rf_we = we_raw;
        // both lanes hit the same register: the younger write is the survivor
        if (same_dest && (&we_raw)) begin
            rf_we[0] = 1'b0;
        end
    end

    // Valid bits and performance counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid   <= '0;
            retire_cnt <= '0;
            excp_cnt   <= '0;
        end else begin
            if (flush_any) begin
                ws_valid <= '0;
            end else if (ws_allowin) begin
                ws_valid <= in_valid;
            end
            retire_cnt <= retire_cnt + CNT_W'(retire_num);
            excp_cnt   <= excp_cnt + CNT_W'(excp_flush);
        end
    end

    // Group payload capture; blocked on a flush edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= '0;
            gr_we_q  <= '0;
            dest_q   <= '0;
            result_q <= '0;
            excp_q   <= '0;
            ertn_q   <= '0;
            eva_q    <= '0;
        end else if (ws_allowin && (|ms_to_ws_valid) && !flush_any) begin
            pc_q     <= ms_pc;
            gr_we_q  <= ms_gr_we;
            dest_q   <= ms_dest;
            result_q <= ms_result;
            excp_q   <= ms_excp_num;
            ertn_q   <= ms_ertn;
            eva_q    <= ms_error_va;
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage (LANES=2, CNT_W=4 so counter wrap is reachable).
module tb_wb_commit_stage;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXCP_W = 16;
    localparam int unsigned CNT_W  = 4;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic [LANES-1:0]         ms_to_ws_valid;
    logic [LANES*32-1:0]      ms_pc;
    logic [LANES-1:0]         ms_gr_we;
    logic [LANES*5-1:0]       ms_dest;
    logic [LANES*DATA_W-1:0]  ms_result;
    logic [LANES*EXCP_W-1:0]  ms_excp_num;
    logic [LANES-1:0]         ms_ertn;
    logic [LANES*32-1:0]      ms_error_va;
    logic                     break_point;
    logic                     ws_allowin;
    logic [LANES-1:0]         ws_valid;
    logic [LANES-1:0]         rf_we;
    logic [LANES*5-1:0]       rf_waddr;
    logic [LANES*DATA_W-1:0]  rf_wdata;
    logic                     excp_flush;
    logic                     ertn_flush;
    logic [3:0]               excp_idx;
    logic [31:0]              csr_era;
    logic                     va_error;
    logic [31:0]              bad_va;
    logic [CNT_W-1:0]         retire_cnt;
    logic [CNT_W-1:0]         excp_cnt;

    wb_commit_stage #(
        .LANES (LANES), .DATA_W(DATA_W), .EXCP_W(EXCP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we),
        .ms_dest(ms_dest), .ms_result(ms_result), .ms_excp_num(ms_excp_num),
        .ms_ertn(ms_ertn), .ms_error_va(ms_error_va), .break_point(break_point),
        .ws_allowin(ws_allowin), .ws_valid(ws_valid), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .excp_flush(excp_flush),
        .ertn_flush(ertn_flush), .excp_idx(excp_idx), .csr_era(csr_era),
        .va_error(va_error), .bad_va(bad_va), .retire_cnt(retire_cnt),
        .excp_cnt(excp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic        ef;
        logic        rf;
        logic [3:0]  idx;
        logic [31:0] era;
        logic        va;
        logic [31:0] bva;
        logic [3:0]  rc;
        logic [3:0]  ec;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] rc_m = 4'd0;
    logic [3:0] ec_m = 4'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] we, input logic [4:0] d0, input logic [4:0] d1,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic [15:0] x0, input logic [15:0] x1,
                         input logic [1:0] er, input logic [31:0] eva0);
        ms_to_ws_valid = v;
        ms_pc          = {pc1, pc0};
        ms_gr_we       = we;
        ms_dest        = {d1, d0};
        ms_result      = {r1, r0};
        ms_excp_num    = {x1, x0};
        ms_ertn        = er;
        ms_error_va    = {32'h0, eva0};
    endtask

    // Push the expected commit of the group currently on the inputs
    task automatic expect_commit(input logic [1:0] we, input logic ef, input logic rf,
                                 input logic [3:0] idx, input logic [31:0] era,
                                 input logic va, input logic [31:0] bva,
                                 input int unsigned rinc);
        exp_t e;
        e.we = we; e.waddr = ms_dest; e.wdata = ms_result;
        e.ef = ef; e.rf = rf; e.idx = idx; e.era = era; e.va = va; e.bva = bva;
        e.rc = rc_m; e.ec = ec_m;
        sb.push_back(e);
        rc_m = rc_m + 4'(rinc);
        ec_m = ec_m + 4'(ef);
    endtask

    task automatic launch();
        @(posedge clk);
        #1;
        ms_to_ws_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every commit cycle pops one expected record
    always @(negedge clk) begin
        exp_t e;
        if (resetn && (|ws_valid) && !break_point) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: commit seen with ws_valid=%b, none expected", ws_valid);
            end else begin
                e = sb.pop_front();
                chk("rf_we",      64'(rf_we),      64'(e.we));
                chk("rf_waddr",   64'(rf_waddr),   64'(e.waddr));
                chk("rf_wdata",   rf_wdata,        e.wdata);
                chk("excp_flush", 64'(excp_flush), 64'(e.ef));
                chk("ertn_flush", 64'(ertn_flush), 64'(e.rf));
                chk("va_error",   64'(va_error),   64'(e.va));
                chk("retire_cnt", 64'(retire_cnt), 64'(e.rc));
                chk("excp_cnt",   64'(excp_cnt),   64'(e.ec));
                if (e.ef || e.rf) begin
                    chk("excp_idx", 64'(excp_idx), 64'(e.idx));
                    chk("csr_era",  64'(csr_era),  64'(e.era));
                    chk("bad_va",   64'(bad_va),   64'(e.bva));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        break_point = 1'b0;
        drive(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ws_valid",   64'(ws_valid),   64'd0);
        chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);
        chk("rst_excp_cnt",   64'(excp_cnt),   64'd0);
        chk("rst_rf_we",      64'(rf_we),      64'd0);
        chk("rst_excp_flush", 64'(excp_flush), 64'd0);
        chk("rst_allowin",    64'(ws_allowin), 64'd1);
        resetn = 1'b1;
        idle(1);

        // Dual commit
        drive(2'b11, 32'h1c000000, 32'h1c000004, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 0, 0, 2'b00, 0);
        expect_commit(2'b11, 0, 0, 0, 0, 0, 0, 2);
        launch();

        // Same destination: younger lane wins
        drive(2'b11, 32'h1c000008, 32'h1c00000c, 2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 0, 0, 2'b00, 0);
        expect_commit(2'b10, 0, 0, 0, 0, 0, 0, 2);
        launch();

        // Lane-0 ALE kills lane 1; capture blocked on the flush edge
        drive(2'b11, 32'h1c000010, 32'h1c000014, 2'b11, 5'd6, 5'd7, 32'h33, 32'h44,
              16'h0200, 0, 2'b00, 32'h10000003);
        expect_commit(2'b00, 1, 0, 4'd9, 32'h1c000010, 1, 32'h10000003, 0);
        @(posedge clk);
        #1;
        drive(2'b11, 32'h1c000018, 32'h1c00001c, 2'b11, 5'd8, 5'd9, 32'h1, 32'h2, 0, 0, 2'b00, 0);
        @(posedge clk);
        #1;
        chk("flush_blocks_capture", 64'(ws_valid), 64'd0);
        ms_to_ws_valid = '0;
        idle(1);

        // Lane-1 SYS: lane 0 still retires and writes
        drive(2'b11, 32'h1c000020, 32'h1c000024, 2'b11, 5'd9, 5'd10, 32'h55, 32'h56,
              0, 16'h0020, 2'b00, 0);
        expect_commit(2'b01, 1, 0, 4'd5, 32'h1c000024, 0, 0, 1);
        launch();
        idle(1);

        // Lane-0 ertn: ertn flush, lane 1 killed, ertn lane retires
        drive(2'b11, 32'h1c000030, 32'h1c000034, 2'b10, 5'd0, 5'd11, 32'h0, 32'h57, 0, 0, 2'b01, 0);
        expect_commit(2'b00, 0, 1, 4'd0, 32'h1c000030, 0, 0, 1);
        launch();
        idle(1);

        // Stall for three cycles, then exactly one commit
        break_point = 1'b1;
        drive(2'b11, 32'h1c000040, 32'h1c000044, 2'b11, 5'd12, 5'd13, 32'h66, 32'h77, 0, 0, 2'b00, 0);
        expect_commit(2'b11, 0, 0, 0, 0, 0, 0, 2);
        launch();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_allowin",  64'(ws_allowin), 64'd0);
            chk("stall_rf_we",    64'(rf_we),      64'd0);
            chk("stall_ws_valid", 64'(ws_valid),   64'd3);
            chk("stall_retire",   64'(retire_cnt), 64'd6);
        end
        @(posedge clk);
        #1;
        break_point = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_single_commit", 64'(ws_valid), 64'd0);

        // Lane 1 without lane 0 is dropped
        drive(2'b10, 32'h1c000050, 32'h1c000054, 2'b11, 5'd1, 5'd2, 32'h9, 32'h9, 0, 0, 2'b00, 0);
        @(posedge clk);
        #1;
        chk("lane1_only_dropped", 64'(ws_valid), 64'd0);
        ms_to_ws_valid = '0;

        // Write to r0 is suppressed but still retires
        drive(2'b11, 32'h1c000058, 32'h1c00005c, 2'b11, 5'd0, 5'd14, 32'h87, 32'h88, 0, 0, 2'b00, 0);
        expect_commit(2'b10, 0, 0, 0, 0, 0, 0, 2);
        launch();

        // Five single retires bring the 4-bit counter to 15, then a dual wraps it to 1
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, 32'h1c000060 + 32'(k * 4), 0, 2'b01, 5'd1, 0, 32'(k + 1), 0, 0, 0, 2'b00, 0);
            expect_commit(2'b01, 0, 0, 0, 0, 0, 0, 1);
            launch();
        end
        drive(2'b11, 32'h1c000074, 32'h1c000078, 2'b11, 5'd2, 5'd3, 32'hC1, 32'hC2, 0, 0, 2'b00, 0);
        expect_commit(2'b11, 0, 0, 0, 0, 0, 0, 2);
        launch();
        idle(1);
        chk("retire_wrap", 64'(retire_cnt), 64'd1);

        // ADEF + higher-numbered bit: bit 1 wins, bad_va = pc
        drive(2'b11, 32'h1c000080, 32'h1c000084, 2'b11, 5'd4, 5'd15, 32'h1, 32'h2,
              16'h8002, 0, 2'b00, 32'hdead0000);
        expect_commit(2'b00, 1, 0, 4'd1, 32'h1c000080, 1, 32'h1c000080, 0);
        launch();
        idle(1);
        chk("excp_cnt_after_adef", 64'(excp_cnt), 64'd3);

        // Asynchronous reset between edges with a live group
        drive(2'b11, 32'h1c000090, 32'h1c000094, 2'b11, 5'd6, 5'd7, 32'h1, 32'h2, 0, 0, 2'b00, 0);
        launch();
        chk("pre_reset_valid", 64'(ws_valid), 64'd3);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_ws_valid", 64'(ws_valid),   64'd0);
        chk("async_retire",   64'(retire_cnt), 64'd0);
        chk("async_excp",     64'(excp_cnt),   64'd0);
        chk("async_rf_we",    64'(rf_we),      64'd0);
        rc_m = 4'd0;
        ec_m = 4'd0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        drive(2'b11, 32'h1c0000a0, 32'h1c0000a4, 2'b11, 5'd8, 5'd9, 32'hE1, 32'hE2, 0, 0, 2'b00, 0);
        expect_commit(2'b11, 0, 0, 0, 0, 0, 0, 2);
        launch();
        idle(3);

        chk("sb_drained",   64'(sb.size()),  64'd0);
        chk("final_retire", 64'(retire_cnt), 64'd2);
        chk("final_excp",   64'(excp_cnt),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
